// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage operand muxes and alu_seq.
// The master drives the request side; the slave (alu_seq) returns result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUCtl;
  logic [WIDTH-1:0] OP1;
  logic [WIDTH-1:0] OP2;
  logic [WIDTH-1:0] Res;
  logic             ZF;
  logic             CF;
  logic             OF;
  logic             ERR;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUCtl, OP1, OP2,
    input  Res, ZF, CF, OF, ERR, busy, done
  );

  modport slave (
    input  start, ALUCtl, OP1, OP2,
    output Res, ZF, CF, OF, ERR, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiply, launched with a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef struct packed {
    logic             ok;
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             of;
  } alu_out_t;

  // Single-cycle operations; ok=0 flags an opcode this function does not handle.
  function automatic alu_out_t alu_single(input logic [3:0]       op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    alu_out_t                o;
    logic [WIDTH:0]          sum;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    o      = '0;
    o.ok   = 1'b1;
    sa     = a;
    sb     = b;
    sh     = b[SHW-1:0];
    sum    = '0;
    case (op)
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_XOR:  o.res = a ^ b;
      OP_NOR:  o.res = ~(a | b);
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        o.res = sum[WIDTH-1:0];
        o.cf  = sum[WIDTH];
        o.of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // CF is the inverted borrow of a + ~b + 1
        sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        o.res = sum[WIDTH-1:0];
        o.cf  = sum[WIDTH];
        o.of  = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  o.res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: o.res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  o.res = a << sh;
      OP_SRL:  o.res = a >> sh;
      OP_SRA:  o.res = sa >>> sh;
      default: o.ok  = 1'b0;
    endcase
    return o;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  alu_out_t         alu_r;
  logic [WIDTH-1:0] mul_acc_nx;

  assign alu_r      = alu_single(bus.ALUCtl, bus.OP1, bus.OP2);
  assign mul_acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    of_d     = of_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ALUCtl == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = bus.OP1;
            mplier_d = bus.OP2;
          end else if (bus.ALUCtl == OP_NOP) begin
            done_d = 1'b1;
          end else begin
            res_d  = alu_r.ok ? alu_r.res : '0;
            cf_d   = alu_r.ok & alu_r.cf;
            of_d   = alu_r.ok & alu_r.of;
            err_d  = ~alu_r.ok;
            zf_d   = (res_d == '0);
            done_d = 1'b1;
          end
        end
      end
      default: begin
        // One multiplier bit consumed per edge; the last edge writes the result
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          res_d   = mul_acc_nx;
          zf_d    = (mul_acc_nx == '0);
          cf_d    = 1'b0;
          of_d    = 1'b0;
          err_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          acc_d    = mul_acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zf_q    <= 1'b1;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign bus.Res  = res_q;
  assign bus.ZF   = zf_q;
  assign bus.CF   = cf_q;
  assign bus.OF   = of_q;
  assign bus.ERR  = err_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q == S_MUL);
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the datapath's combinational 32-bit ALU. It keeps the existing 3-bit ALUCtl encodings on the low bits of a 4-bit opcode, adds XOR/NOR/SLTU/shifts, and adds an iterative multi-cycle multiply. Each operation is launched with a start/busy/done handshake, and results and flags are registered. It sits in the execute stage, between the operand muxes and the result/branch logic.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 4. Local SHW = $clog2(WIDTH).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on an edge where start=1 and busy=0.
- ALUCtl  input  4  opcode; sampled only on the accepting edge.
- OP1  input  WIDTH  operand A; sampled only on the accepting edge.
- OP2  input  WIDTH  operand B / shift amount; sampled only on the accepting edge.
- Res  output  WIDTH  registered result; held until the next completion.
- ZF  output  1  registered, equals (Res==0).
- CF  output  1  carry flag (ADD/SUB only, else 0).
- OF  output  1  signed-overflow flag (ADD/SUB only, else 0).
- ERR  output  1  invalid opcode on the last completion.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse: Res and flags updated (or NOP retired).

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 0/1); 0011 NOP.
  - 1000 SLTU; 1001 XOR; 1010 NOR.
  - 1100 SLL, 1101 SRL, 1110 SRA, each by OP2[SHW-1:0].
  - 1011 MUL. All other codes are invalid.
- Arithmetic:
  - ADD: {CF,Res} = OP1+OP2. OF = operands have the same sign and the result sign differs.
  - SUB: {CF,Res} = OP1 + ~OP2 + 1, so CF=1 means no borrow. OF = operand signs differ and the result sign differs from OP1.
  - All arithmetic wraps modulo 2^WIDTH.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle, WIDTH iterations.
  - Res = low WIDTH bits of the product (identical for signed operands). CF=OF=0.
- NOP: done pulses. Res, ZF, CF, OF and ERR are unchanged.
- Invalid opcode: Res=0, ZF=1, CF=OF=0, ERR=1, done pulses.
- Any valid completion clears ERR.
- FSM states:
  - IDLE → IDLE on accepted single-cycle op, NOP or invalid.
  - IDLE → MUL on accepted MUL: operands latched, iteration counter=0, busy=1.
  - MUL → MUL while counter < WIDTH-1; counter increments each edge.
  - MUL → IDLE on the edge where counter = WIDTH-1: Res/flags written, done=1, busy=0.
- start while busy=1 is ignored entirely; it is not queued.
- Input changes after the accepting edge do not affect the result in progress.

## Timing
- Reset values: Res=0, ZF=1, CF=0, OF=0, ERR=0, busy=0, done=0, FSM=IDLE, counter=0.
- rst has priority over start.
- rst asserted mid-MUL aborts the operation: no done, outputs return to reset values at that edge.
- Single-cycle ops, NOP, invalid: accepted at edge k; Res/flags/done valid after edge k. Latency 1, done high for exactly one cycle.
- MUL accepted at edge k:
  - busy=1 after edges k … k+WIDTH-1.
  - Result and done=1 after edge k+WIDTH, with busy=0 in the same cycle.
- done is 0 in every cycle not listed above.
- Back-to-back throughput:
  - A start in the cycle where done=1 and busy=0 is accepted.
  - Single-cycle ops can complete every cycle, one per cycle.
- Res/flags hold between completions regardless of input activity.

## Test plan
- Reset, then AND 0xF0F0F0F0 & 0x0F0F0F0F → done one cycle later, Res=0x00000000, ZF=1. Next cycle OR of the same operands → Res=0xFFFFFFFF, ZF=0.
- ADD 0x7FFFFFFF + 0x00000001 → Res=0x80000000, OF=1, CF=0. SUB 20-5 → Res=15, ZF=0, CF=1. SUB 7-7 → Res=0, ZF=1, CF=1.
- SLT 0xFFFFFFFF vs 0x00000001 → Res=1. SLTU with the same operands → Res=0. SRA 0x80000000 by 4 → Res=0xF8000000. SLL 1 by 31 → Res=0x80000000.
- MUL 123 × 456 → Res=0x0000DB18 (56088), done exactly 32 edges after acceptance, busy high for 32 cycles. An AND start pulsed mid-MUL is ignored: no extra done, Res unaffected.
- MUL started, rst asserted at iteration 10 → busy=0, Res=0, ZF=1, done never pulses. Next ADD 10+15 → Res=25 after one cycle.
- ADD 10+15 (Res=25), then NOP → done pulses, Res=25, ERR=0. Then opcode 0100 → Res=0, ZF=1, ERR=1. Then OR 1|2 → Res=3, ERR=0.
